// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer (IDLE/REQ/WAIT/HOLD).
// Optional misaligned-redirect trap is built when PC_ALIGN_CHECK_EN is defined.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_addend,
  output logic [31:0] pc_step,
  input  logic [31:0] pc_sum,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        if_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  state_t      redir_state;
  logic        redir_kill;
  logic        kill;
  logic        trap;
  logic [31:0] pc;

`ifdef PC_ALIGN_CHECK_EN
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a;
  endfunction

  assign trap = if_misalign;
`else
  // Without the trap, a misaligned target is silently snapped to a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

  assign trap = 1'b0;
`endif

  assign pc_addend = pc;
  assign pc_step   = PC_STEP;
  assign imem_addr = pc;
  assign imem_req  = (state == REQ) && !stall;

  // A redirect that races an accepted request or a pending response must
  // remember to drop the stale word that is still on its way back.
  always_comb begin
    redir_state = REQ;
    redir_kill  = 1'b0;
    case (state)
      REQ: begin
        if (imem_req && imem_gnt) begin
          redir_state = WAIT;
          redir_kill  = 1'b1;
        end
      end
      WAIT: begin
        if (!imem_rvalid) begin
          redir_state = WAIT;
          redir_kill  = 1'b1;
        end
      end
      default: begin
        redir_state = REQ;
        redir_kill  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= IDLE;
      kill     <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= 32'h0000_0000;
      if_instr <= NOP_INSTR;
`ifdef PC_ALIGN_CHECK_EN
      if_misalign <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc       <= align_pc(redirect_pc);
      state    <= redir_state;
      kill     <= redir_kill;
      if_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      if_misalign <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        state       <= HOLD;
        kill        <= 1'b0;
        if_valid    <= 1'b1;
        if_misalign <= 1'b1;
        if_pc       <= redirect_pc;
        if_instr    <= NOP_INSTR;
      end
`endif
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_req && imem_gnt) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc_sum;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (if_ready && !stall && !trap) begin
            if_valid <= 1'b0;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
